signed_divider: RTL

Sequential 8-bit signed integer divider: the inverse datapath to the team's sequential Booth multiplier in the 8-bit FPGA computer's arithmetic unit. It accepts a dividend and divisor on a start pulse and runs one restoring shift-subtract iteration per clock. It returns a truncated-toward-zero quotient and a remainder carrying the dividend's sign, then signals `ready`.

---
 rtl/signed_divider_pkg.sv | 15 +
 rtl/div_step.sv | 24 ++
 rtl/twos_compliment.sv | 11 +
 rtl/signed_divider.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/signed_divider_pkg.sv
// Shared definitions for the sequential signed divider: FSM states, data width, iteration count.
package signed_divider_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ITER_CNT = 8;
  localparam int unsigned CNT_W    = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring shift-subtract iteration on the {rem, q} pair.
module div_step
  import signed_divider_pkg::*;
(
  input  logic [DATA_W:0]   i_rem,
  input  logic [DATA_W-1:0] i_q,
  input  logic [DATA_W-1:0] i_divisor,
  output logic [DATA_W:0]   o_rem,
  output logic [DATA_W-1:0] o_q
);

  logic [DATA_W:0] w_shift;
  logic [DATA_W:0] w_trial;
  logic            w_ge;

  // rem stays below the divisor, so the shifted value always fits in 9 bits
  assign w_shift = {i_rem[DATA_W-1:0], i_q[DATA_W-1]};
  assign w_ge    = i_rem[DATA_W] | (w_shift >= {1'b0, i_divisor});
  assign w_trial = w_shift - {1'b0, i_divisor};

  assign o_rem = w_ge ? w_trial : w_shift;
  assign o_q   = {i_q[DATA_W-2:0], w_ge};

endmodule

// File: rtl/twos_compliment.sv
// Two's-complement negation of an 8-bit value (wraps modulo 256).
module twos_compliment
  import signed_divider_pkg::*;
(
  input  logic [DATA_W-1:0] i_value,
  output logic [DATA_W-1:0] o_value
);

  assign o_value = ~i_value + DATA_W'(1);

endmodule

// File: rtl/signed_divider.sv
// Sequential 8-bit signed divider: truncating quotient, remainder takes the dividend's sign.
// Optional DIV_ERR_FLAGS_EN enables div_by_zero/overflow flags and the B=0 quotient override.
module signed_divider
  import signed_divider_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] Quotient,
  output logic [DATA_W-1:0] Remainder,
  output logic              ready,
  output logic              busy,
  output logic              div_by_zero,
  output logic              overflow
);

  localparam logic [CNT_W-1:0] LastIter = CNT_W'(ITER_CNT - 1);

  state_t            r_state, w_state_next;
  logic [DATA_W:0]   r_rem;
  logic [DATA_W-1:0] r_q, r_div;
  logic              r_sign_q, r_sign_r;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_quot, r_remo;
  logic              r_ready;

  logic [DATA_W-1:0] w_neg_a, w_neg_b, w_neg_q, w_neg_r;
  logic [DATA_W-1:0] w_abs_a, w_abs_b;
  logic [DATA_W:0]   w_step_rem;
  logic [DATA_W-1:0] w_step_q;
  logic [DATA_W-1:0] w_fix_q, w_fix_r;

  twos_compliment u_neg_a (.i_value(A),                .o_value(w_neg_a));
  twos_compliment u_neg_b (.i_value(B),                .o_value(w_neg_b));
  twos_compliment u_neg_q (.i_value(r_q),              .o_value(w_neg_q));
  twos_compliment u_neg_r (.i_value(r_rem[DATA_W-1:0]), .o_value(w_neg_r));

  // |-128| wraps to 8'h80, which is the correct unsigned magnitude
  assign w_abs_a = A[DATA_W-1] ? w_neg_a : A;
  assign w_abs_b = B[DATA_W-1] ? w_neg_b : B;

  div_step u_div_step (
    .i_rem     (r_rem),
    .i_q       (r_q),
    .i_divisor (r_div),
    .o_rem     (w_step_rem),
    .o_q       (w_step_q)
  );

`ifdef DIV_ERR_FLAGS_EN
  logic r_dbz, r_dbz_flag, r_ovf_flag;
  logic w_ovf;

  always_comb begin
    w_fix_q = r_sign_q ? w_neg_q : r_q;
    w_fix_r = r_sign_r ? w_neg_r : r_rem[DATA_W-1:0];
    if (r_dbz) w_fix_q = '1;
    // a positive quotient with magnitude >= 128 only arises from -128 / -1
    w_ovf = ~r_sign_q & r_q[DATA_W-1] & ~r_dbz;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dbz      <= 1'b0;
      r_dbz_flag <= 1'b0;
      r_ovf_flag <= 1'b0;
    end else begin
      if ((r_state == StIdle || r_state == StDone) && start) r_dbz <= (B == '0);
      if (r_state == StFix) begin
        r_dbz_flag <= r_dbz;
        r_ovf_flag <= w_ovf;
      end
    end
  end

  assign div_by_zero = r_dbz_flag;
  assign overflow    = r_ovf_flag;
`else
  always_comb begin
    w_fix_q = r_sign_q ? w_neg_q : r_q;
    w_fix_r = r_sign_r ? w_neg_r : r_rem[DATA_W-1:0];
  end

  assign div_by_zero = 1'b0;
  assign overflow    = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle, StDone: if (start) w_state_next = StRun;
      StRun:          if (r_cnt == LastIter) w_state_next = StFix;
      StFix:          w_state_next = StDone;
      default:        w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_rem    <= '0;
      r_q      <= '0;
      r_div    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_cnt    <= '0;
      r_quot   <= '0;
      r_remo   <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      unique case (r_state)
        StIdle, StDone: begin
          if (start) begin
            r_q      <= w_abs_a;
            r_div    <= w_abs_b;
            r_rem    <= '0;
            r_sign_q <= A[DATA_W-1] ^ B[DATA_W-1];
            r_sign_r <= A[DATA_W-1];
            r_cnt    <= '0;
            r_ready  <= 1'b0;
          end
        end
        StRun: begin
          r_rem <= w_step_rem;
          r_q   <= w_step_q;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        StFix: begin
          r_quot  <= w_fix_q;
          r_remo  <= w_fix_r;
          r_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Quotient  = r_quot;
  assign Remainder = r_remo;
  assign ready     = r_ready;
  assign busy      = (r_state == StRun) || (r_state == StFix);

endmodule
